// File: rtl/seg7_scan_mux_pkg.sv
// Shared display constants and types for multiplexed 7-segment drivers.
// Digit count and off patterns are reused by num_to_seg7_0_9 users.
package seg7_scan_mux_pkg;

  localparam int unsigned NUM_DIGITS = 3;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned IDX_W      = 2;

  localparam logic [SEG_W-1:0] SEG_OFF_ACT_LOW  = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_OFF_ACT_HIGH = 7'h00;

  typedef struct packed {
    logic             dpt;
    logic [SEG_W-1:0] seg;
  } digit_t;

  function automatic logic [SEG_W-1:0] seg_off(input bit act_low);
    return act_low ? SEG_OFF_ACT_LOW : SEG_OFF_ACT_HIGH;
  endfunction

  function automatic logic [NUM_DIGITS-1:0] dig_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_DIGITS-1:0] oh;
    oh = '0;
    case (idx)
      IDX_W'(0): oh = 3'b001;
      IDX_W'(1): oh = 3'b010;
      IDX_W'(2): oh = 3'b100;
      default:   oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot timer: registered enable, per-slot cycle counter and digit index.
// frame_end_c marks the last cycle of the last digit slot while running.
module scan_timer
  import seg7_scan_mux_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  localparam int unsigned CNT_W   = $clog2(SCAN_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             run,
  output logic [CNT_W-1:0] cnt,
  output logic [IDX_W-1:0] idx,
  output logic             frame_end_c
);

  logic slot_end_c;
  logic last_idx_c;

  assign slot_end_c  = run && (cnt == CNT_W'(SCAN_DIV - 1));
  assign last_idx_c  = (idx == IDX_W'(NUM_DIGITS - 1));
  assign frame_end_c = slot_end_c && last_idx_c;

  // Counter and index freeze whenever run is low, so en toggles resume in place.
  always_ff @(posedge clk) begin
    if (!rst) begin
      run <= 1'b0;
      cnt <= '0;
      idx <= '0;
    end else begin
      run <= en;
      if (run) begin
        if (slot_end_c) begin
          cnt <= '0;
          idx <= last_idx_c ? '0 : idx + IDX_W'(1);
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Three-digit 7-segment scan multiplexer with frame-coherent shadow registers
// and per-slot blanking; outputs decode registered state only.
module seg7_scan_mux
  import seg7_scan_mux_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 500,
  parameter bit          ACT_LOW   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SEG_W-1:0] seg7_0,
  input  logic [SEG_W-1:0] seg7_1,
  input  logic [SEG_W-1:0] seg7_2,
  input  logic             seg7_0_dpt,
  input  logic             seg7_1_dpt,
  input  logic             seg7_2_dpt,
  output logic [SEG_W-1:0] seg_out,
  output logic             seg_dpt,
  output logic [2:0]       dig_sel,
  output logic             frame_tick
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);

  logic             run;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             frame_end_c;
  digit_t           shadow [NUM_DIGITS];
  digit_t           cur_c;
  logic             active_c;

  scan_timer #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_timer (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .run         (run),
    .cnt         (cnt),
    .idx         (idx),
    .frame_end_c (frame_end_c)
  );

  // Inputs are captured only at the frame boundary so each frame is coherent.
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_tick <= 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      frame_tick <= frame_end_c;
      if (frame_end_c) begin
        shadow[0] <= {seg7_0_dpt, seg7_0};
        shadow[1] <= {seg7_1_dpt, seg7_1};
        shadow[2] <= {seg7_2_dpt, seg7_2};
      end
    end
  end

  // Output decode; only dig_sel is polarity-adjusted, segments pass through.
  always_comb begin
    active_c = run && (cnt >= CNT_W'(BLANK_CYC));
    cur_c    = '0;
    seg_out  = seg_off(ACT_LOW);
    seg_dpt  = ACT_LOW;
    dig_sel  = ACT_LOW ? 3'b111 : 3'b000;
    case (idx)
      IDX_W'(0): cur_c = shadow[0];
      IDX_W'(1): cur_c = shadow[1];
      IDX_W'(2): cur_c = shadow[2];
      default:   cur_c = '0;
    endcase
    if (active_c) begin
      seg_out = cur_c.seg;
      seg_dpt = cur_c.dpt;
      dig_sel = ACT_LOW ? ~dig_onehot(idx) : dig_onehot(idx);
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux (SCAN_DIV=8, BLANK_CYC=2, ACT_LOW=1).
module tb_seg7_scan_mux;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [6:0] seg7_0, seg7_1, seg7_2;
  logic       seg7_0_dpt, seg7_1_dpt, seg7_2_dpt;
  logic [6:0] seg_out;
  logic       seg_dpt;
  logic [2:0] dig_sel;
  logic       frame_tick;

  seg7_scan_mux #(
    .SCAN_DIV  (8),
    .BLANK_CYC (2),
    .ACT_LOW   (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .seg7_0     (seg7_0),
    .seg7_1     (seg7_1),
    .seg7_2     (seg7_2),
    .seg7_0_dpt (seg7_0_dpt),
    .seg7_1_dpt (seg7_1_dpt),
    .seg7_2_dpt (seg7_2_dpt),
    .seg_out    (seg_out),
    .seg_dpt    (seg_dpt),
    .dig_sel    (dig_sel),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [2:0] dsel;
    logic [6:0] seg;
    logic       dpt;
    logic       ft;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   final_chk = 1'b0;
  bit   final_done = 1'b0;

  task automatic push(input int c, input logic [2:0] d, input logic [6:0] s,
                      input logic p, input logic f, input string n);
    exp_t e;
    e.c = c; e.dsel = d; e.seg = s; e.dpt = p; e.ft = f; e.name = n;
    sb.push_back(e);
  endtask

  task automatic push_off(input int c, input string n);
    push(c, 3'b111, 7'h7F, 1'b1, 1'b0, n);
  endtask

  // One 24-cycle frame: per slot 2 blank cycles then 6 active cycles.
  task automatic push_frame(input int base, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic p0, input logic p1,
                            input logic p2, input logic ft0, input int pause_q,
                            input int pause_len, input int stop_q, input string n);
    logic [2:0] dsel_tbl [3];
    logic [6:0] seg_tbl  [3];
    logic       dpt_tbl  [3];
    int         off;
    int         s;
    int         j;
    dsel_tbl = '{3'b110, 3'b101, 3'b011};
    seg_tbl  = '{s0, s1, s2};
    dpt_tbl  = '{p0, p1, p2};
    off = 0;
    for (int q = 0; q < stop_q; q++) begin
      if (q == pause_q) begin
        for (int k = 0; k < pause_len; k++) push_off(base + q + k, {n, "_paused"});
        off = pause_len;
      end
      s = q / 8;
      j = q % 8;
      if (j < 2) push(base + q + off, 3'b111, 7'h7F, 1'b1, ft0 && (q == 0), n);
      else       push(base + q + off, dsel_tbl[s], seg_tbl[s], dpt_tbl[s], 1'b0, n);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: one-hot check every cycle, scoreboard pops for scheduled cycles.
  always @(negedge clk) begin
    exp_t e;
    if (cyc > 0) begin
      checks++;
      if (!$onehot0(~dig_sel)) begin
        errors++;
        $display("FAIL onehot cyc=%0d dig_sel=%b (required at most one low bit)", cyc, dig_sel);
      end
    end
    while (sb.size() > 0 && sb[0].c <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.c != cyc) begin
        errors++;
        $display("FAIL %s missed cyc=%0d (now %0d)", e.name, e.c, cyc);
      end else if ({dig_sel, seg_out, seg_dpt, frame_tick} !== {e.dsel, e.seg, e.dpt, e.ft}) begin
        errors++;
        $display("FAIL %s cyc=%0d got dig_sel=%b seg=%h dpt=%b ft=%b, want dig_sel=%b seg=%h dpt=%b ft=%b",
                 e.name, cyc, dig_sel, seg_out, seg_dpt, frame_tick, e.dsel, e.seg, e.dpt, e.ft);
      end
    end
    if (final_chk && !final_done) begin
      final_done = 1'b1;
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
      end
    end
  end

  initial begin
    int r;
    rst = 1'b0; en = 1'b0;
    seg7_0 = 7'h40; seg7_1 = 7'h79; seg7_2 = 7'h24;
    seg7_0_dpt = 1'b1; seg7_1_dpt = 1'b0; seg7_2_dpt = 1'b1;
    r = 3;

    for (int c = 1; c <= r; c++) push_off(c, "reset");
    push_frame(r + 1,   7'h00, 7'h00, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0, 24, "frame0");
    push_frame(r + 25,  7'h40, 7'h79, 7'h24, 1'b1, 1'b0, 1'b1, 1'b1, -1, 0, 24, "frame1");
    push_frame(r + 49,  7'h40, 7'h06, 7'h24, 1'b1, 1'b0, 1'b1, 1'b1, -1, 0, 24, "frame2");
    push_frame(r + 73,  7'h40, 7'h06, 7'h24, 1'b1, 1'b0, 1'b1, 1'b1, 13, 10, 24, "frame3_pause");
    push_frame(r + 107, 7'h40, 7'h06, 7'h24, 1'b1, 1'b0, 1'b1, 1'b1, -1, 0, 23, "frame4");
    push_off(r + 130, "rst_mid_frame");
    push_frame(r + 131, 7'h00, 7'h00, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0, 24, "post_rst0");
    push_frame(r + 155, 7'h40, 7'h06, 7'h24, 1'b1, 1'b0, 1'b1, 1'b1, -1, 0, 24, "post_rst1");

    wait_cyc(r);       rst = 1'b1; en = 1'b1;
    wait_cyc(r + 29);  seg7_1 = 7'h06;
    wait_cyc(r + 85);  en = 1'b0;
    wait_cyc(r + 95);  en = 1'b1;
    wait_cyc(r + 129); rst = 1'b0;
    wait_cyc(r + 130); rst = 1'b1;
    wait_cyc(r + 182);

    repeat (10000) begin
      @(posedge clk);
      #1;
      en  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 15) != 0);
    end

    final_chk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_mux.md
SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000; clk cycles per digit slot, legal range >= 4.
REQ-002 SHALL have parameter BLANK_CYC, default 500; blanking cycles at the start of each slot, legal range 1 .. SCAN_DIV-2.
REQ-003 SHALL have parameter ACT_LOW, default 1; 1 = segments, dpt and digit selects are driven active-low.
REQ-004 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-low (rst=0 resets on the next rising clk edge).
REQ-006 SHALL have port en  input  1  scan enable.
REQ-007 SHALL have ports seg7_0, seg7_1, seg7_2  input  7 each  digit 0/1/2 segment codes, in the same polarity as the outputs.
REQ-008 SHALL have ports seg7_0_dpt, seg7_1_dpt, seg7_2_dpt  input  1 each  digit 0/1/2 decimal points.
REQ-009 SHALL have port seg_out  output  7  shared segment bus.
REQ-010 SHALL have port seg_dpt  output  1  shared decimal-point line.
REQ-011 SHALL have port dig_sel  output  3  digit enables, one-hot (bit i = digit i) when active.
REQ-012 SHALL have port frame_tick  output  1  one-cycle pulse at each frame load.

Function
REQ-013 SHALL hold counter cnt (0..SCAN_DIV-1), digit index idx (0..2) and flag run (en registered).
REQ-014 SHALL, on each cycle with run=1, increment cnt; at cnt=SCAN_DIV-1 it SHALL wrap cnt to 0 and advance idx 0->1->2->0.
REQ-015 SHALL hold cnt and idx unchanged while run=0.
REQ-016 SHALL load shadow registers from all six inputs and pulse frame_tick for exactly one cycle when run=1, cnt=SCAN_DIV-1 and idx=2 (the frame boundary).
REQ-017 SHALL ignore input changes at all other times, so every displayed frame is coherent.
REQ-018 SHALL make outputs a pure decode of registers, with no combinational path from any input.
REQ-019 SHALL drive dig_sel = onehot(idx) and seg_out/seg_dpt = shadow[idx] when run=1 and cnt>=BLANK_CYC.
REQ-020 SHALL otherwise drive dig_sel all-inactive and seg_out/seg_dpt to the off level (ACT_LOW=1: 7'b1111111/1; ACT_LOW=0: all 0).
REQ-021 SHALL apply ACT_LOW inversion to dig_sel only; segment inputs pass through unmodified.
REQ-022 SHALL, when en rises, resume at the held cnt/idx one cycle later; no counter reset and no frame load occur on en edges.
REQ-023 SHALL hold dig_sel at most one-hot in every cycle, including the cycles around slot and frame wraps.

Reset
REQ-024 SHALL, while rst=0, set cnt=0, idx=0, run=0, shadow=0 and frame_tick=0, with outputs at the off level.
REQ-025 SHALL let reset applied mid-slot or mid-frame take effect at the next edge and abort the current frame; the first frame load after reset occurs 3*SCAN_DIV enabled cycles later.

Structure
REQ-026 SHALL place the digit-count constant (3) and the off-pattern constants in the shared display package, reused by num_to_seg7_0_9 users.
REQ-027 SHALL build the slot timer as one sub-module, scan_timer (cnt/idx/wrap strobes); the shadow registers and output decode stay in the top.

Verification (SCAN_DIV=8, BLANK_CYC=2, ACT_LOW=1)
REQ-028 SHALL check: reset, then en=1 held -> first frame_tick 24+1 cycles after rst releases (+1 for run); dig_sel sequence per slot is 111,111, then 110 x6, then 101, then 011.
REQ-029 SHALL check: seg7_1=7'h06 applied mid-frame -> seg_out unchanged until after the next frame_tick, then 7'h06 during the digit-1 active window.
REQ-030 SHALL check: en dropped at cnt=5, idx=1 for 10 cycles -> dig_sel=111 one cycle later; scanning resumes at cnt=5, idx=1.
REQ-031 SHALL check: rst=0 for 1 cycle at cnt=6, idx=2 -> next cycle cnt=0, idx=0, seg_out=7'h7F, and no frame_tick.
REQ-032 SHALL check: a one-hot assertion on dig_sel with random en and rst over 10k cycles -> zero violations.
